// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel adjust stream: point-operation modes,
// default geometry, and helpers used by the datapath.
package pixel_pkg;

  localparam int DEF_CW    = 8;
  localparam int DEF_NCH   = 3;
  localparam int DEF_GW    = 8;
  localparam int DEF_GFRAC = 4;
  localparam int DEF_CNT_W = 24;

  typedef enum logic [2:0] {
    MODE_BYPASS = 3'd0,
    MODE_ADD    = 3'd1,
    MODE_SUB    = 3'd2,
    MODE_GAIN   = 3'd3,
    MODE_INVERT = 3'd4
  } mode_e;

  // Largest value a channel of width cw can hold (valid for cw < 32).
  function automatic int unsigned chan_max(input int unsigned cw);
    return (32'd1 << cw) - 32'd1;
  endfunction

  // Unused encodings 5..7 fall back to bypass.
  function automatic mode_e decode_mode(input logic [2:0] raw);
    mode_e m;
    case (raw)
      3'd1:    m = MODE_ADD;
      3'd2:    m = MODE_SUB;
      3'd3:    m = MODE_GAIN;
      3'd4:    m = MODE_INVERT;
      default: m = MODE_BYPASS;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pixel_adjust_stream_if.sv
// Valid/ready pixel stream bundle. A beat transfers on a rising clock edge
// when valid & ready; the master holds data/sof/eof stable while valid is
// high and ready is low, and never withdraws valid before the transfer.
interface pixel_adjust_stream_if #(
  parameter int DW = 24
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          sof;
  logic          eof;

  modport master (output valid, output data, output sof, output eof, input ready);
  modport slave  (input valid, input data, input sof, input eof, output ready);
endinterface

// File: rtl/pixel_adjust_chan.sv
// Combinational per-channel point operator; every path saturates into the
// channel range so the result never wraps.
module pixel_adjust_chan
  import pixel_pkg::*;
#(
  parameter int CW    = DEF_CW,
  parameter int GW    = DEF_GW,
  parameter int GFRAC = DEF_GFRAC
) (
  input  mode_e          i_mode,
  input  logic [CW-1:0]  i_offset,
  input  logic [GW-1:0]  i_gain,
  input  logic [CW-1:0]  i_ch,
  output logic [CW-1:0]  o_ch
);

  localparam logic [CW-1:0] MAXV = CW'(chan_max(CW));

  logic [CW:0]       w_sum;
  logic [CW+GW-1:0]  w_prod;
  logic [CW+GW-1:0]  w_scaled;

  assign w_sum    = {1'b0, i_ch} + {1'b0, i_offset};
  assign w_prod   = {{GW{1'b0}}, i_ch} * {{CW{1'b0}}, i_gain};
  // Truncating shift drops the fractional gain bits before saturation.
  assign w_scaled = w_prod >> GFRAC;

  always_comb begin
    o_ch = i_ch;
    case (i_mode)
      MODE_ADD:    o_ch = w_sum[CW] ? MAXV : w_sum[CW-1:0];
      MODE_SUB:    o_ch = (i_ch >= i_offset) ? (i_ch - i_offset) : '0;
      MODE_GAIN:   o_ch = (|w_scaled[CW+GW-1:CW]) ? MAXV : w_scaled[CW-1:0];
      MODE_INVERT: o_ch = MAXV - i_ch;
      default:     o_ch = i_ch;
    endcase
  end

endmodule

// File: rtl/pixel_adjust_stream.sv
// Two-stage streaming pixel point operator with per-frame configuration
// latched on sof, output frame pixel counter and end-of-frame pulse.
module pixel_adjust_stream
  import pixel_pkg::*;
#(
  parameter int CW    = DEF_CW,
  parameter int NCH   = DEF_NCH,
  parameter int GW    = DEF_GW,
  parameter int GFRAC = DEF_GFRAC,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             cfg_mode,
  input  logic [CW-1:0]          cfg_offset,
  input  logic [GW-1:0]          cfg_gain,
  pixel_adjust_stream_if.slave   s,
  pixel_adjust_stream_if.master  m,
  output logic [CNT_W-1:0]       pix_count,
  output logic                   frame_done
);

  localparam int              DW       = NCH * CW;
  localparam logic [GW-1:0]   GAIN_ONE = GW'(32'd1 << GFRAC);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mode_e           r_cfg_mode;
  logic [CW-1:0]   r_cfg_offset;
  logic [GW-1:0]   r_cfg_gain;

  logic            r_s1_valid;
  logic            r_s1_sof;
  logic            r_s1_eof;
  logic [DW-1:0]   r_s1_data;
  mode_e           r_s1_mode;
  logic [CW-1:0]   r_s1_offset;
  logic [GW-1:0]   r_s1_gain;

  logic            r_m_valid;
  logic            r_m_sof;
  logic            r_m_eof;
  logic [DW-1:0]   r_m_data;
  logic [CNT_W-1:0] r_pix_count;
  logic            r_frame_done;

  logic            w_en;
  logic            w_s_take;
  logic            w_m_take;
  logic            w_load_cfg;
  mode_e           w_cur_mode;
  logic [CW-1:0]   w_cur_offset;
  logic [GW-1:0]   w_cur_gain;
  logic [DW-1:0]   w_result;

  // The whole pipe advances together; a held output stalls everything.
  assign w_en       = !r_m_valid || m.ready;
  assign w_s_take   = s.valid && w_en;
  assign w_m_take   = r_m_valid && m.ready;
  assign w_load_cfg = w_s_take && s.sof;

  // The sof beat itself must already see the new configuration.
  assign w_cur_mode   = w_load_cfg ? decode_mode(cfg_mode) : r_cfg_mode;
  assign w_cur_offset = w_load_cfg ? cfg_offset : r_cfg_offset;
  assign w_cur_gain   = w_load_cfg ? cfg_gain : r_cfg_gain;

  assign s.ready    = w_en;
  assign m.valid    = r_m_valid;
  assign m.data     = r_m_data;
  assign m.sof      = r_m_sof;
  assign m.eof      = r_m_eof;
  assign pix_count  = r_pix_count;
  assign frame_done = r_frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_mode   <= MODE_BYPASS;
      r_cfg_offset <= '0;
      r_cfg_gain   <= GAIN_ONE;
    end else if (w_load_cfg) begin
      r_cfg_mode   <= w_cur_mode;
      r_cfg_offset <= w_cur_offset;
      r_cfg_gain   <= w_cur_gain;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_sof    <= 1'b0;
      r_s1_eof    <= 1'b0;
      r_s1_data   <= '0;
      r_s1_mode   <= MODE_BYPASS;
      r_s1_offset <= '0;
      r_s1_gain   <= GAIN_ONE;
    end else if (w_en) begin
      r_s1_valid  <= s.valid;
      r_s1_sof    <= s.valid && s.sof;
      r_s1_eof    <= s.valid && s.eof;
      r_s1_data   <= s.data;
      r_s1_mode   <= w_cur_mode;
      r_s1_offset <= w_cur_offset;
      r_s1_gain   <= w_cur_gain;
    end
  end

  // Channel 0 sits in the most significant slice.
  for (genvar g = 0; g < NCH; g++) begin : g_chan
    pixel_adjust_chan #(
      .CW    (CW),
      .GW    (GW),
      .GFRAC (GFRAC)
    ) u_chan (
      .i_mode   (r_s1_mode),
      .i_offset (r_s1_offset),
      .i_gain   (r_s1_gain),
      .i_ch     (r_s1_data[(NCH-1-g)*CW +: CW]),
      .o_ch     (w_result[(NCH-1-g)*CW +: CW])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_sof   <= 1'b0;
      r_m_eof   <= 1'b0;
      r_m_data  <= '0;
    end else if (w_en) begin
      r_m_valid <= r_s1_valid;
      r_m_sof   <= r_s1_sof;
      r_m_eof   <= r_s1_eof;
      r_m_data  <= w_result;
    end
  end

  // Counter holds between frames so the last frame length stays readable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_count  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_m_take && r_m_eof;
      if (w_m_take) begin
        if (r_m_sof)
          r_pix_count <= CNT_W'(1);
        else if (r_pix_count != CNT_MAX)
          r_pix_count <= r_pix_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pixel_adjust_stream.md
Name: pixel_adjust_stream

Overview:
Parametrised, pipelined streaming successor to the combinational brightness block. It applies a per-frame, selectable point operation to packed multi-channel pixels: bypass, saturating add, saturating subtract, fixed-point gain, or invert. It sits between the pixel source (hex-file reader or camera front end) and the pixel sink, using valid/ready handshakes on both sides. It also reports per-frame pixel counts and an end-of-frame pulse.

Parameters:
CW, 8, bits per channel
NCH, 3, channels per pixel; channel 0 occupies the MSBs (R,G,B order for NCH=3)
GW, 8, gain width, unsigned fixed point
GFRAC, 4, fractional bits of gain (0x10 = 1.0 at defaults)
CNT_W, 24, width of the pixel counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
cfg_mode  in  3  0 bypass, 1 add, 2 sub, 3 gain, 4 invert, 5-7 treated as bypass
cfg_offset  in  CW  offset for add/sub modes
cfg_gain  in  GW  gain for gain mode
s_valid  in  1  input beat valid
s_ready  out  1  block accepts input beat
s_data  in  NCH*CW  packed input pixel
s_sof  in  1  beat is first pixel of frame
s_eof  in  1  beat is last pixel of frame
m_valid  out  1  output beat valid
m_ready  in  1  sink accepts output beat
m_data  out  NCH*CW  packed processed pixel
m_sof  out  1  sof aligned with m_data
m_eof  out  1  eof aligned with m_data
pix_count  out  CNT_W  beats transferred on output since last m_sof, inclusive
frame_done  out  1  one-cycle pulse after m_eof handshake

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, m_sof=0, m_eof=0, pix_count=0, frame_done=0, both stage valids=0, active config = mode 0, offset 0, gain 0x10. In-flight beats are dropped.
- Pipeline: 2 register stages, stage 1 = input capture plus active config, stage 2 = result. Latency is exactly 2 cycles from s handshake to m_valid when unstalled. Throughput is 1 pixel/clk.
- Stall: en = !m_valid | m_ready; s_ready = en (combinational from m_ready). Both stages advance only when en=1. When en=0, all stage registers, including m_data, hold. Bubbles are not collapsed.
- Handshake: a beat transfers when valid & ready. m_data, m_sof and m_eof remain stable while m_valid=1 and m_ready=0.
- Config latch: on an accepted beat with s_sof=1, the active config loads from cfg_*. That beat and all following beats use the new config. cfg_* is ignored at all other times. Before the first sof after reset, the reset config (bypass) applies.
- Per-channel arithmetic, channels independent:
  - add: min(ch+offset, 2^CW-1), using a CW+1 bit intermediate.
  - sub: max(ch-offset, 0).
  - gain: (ch*gain)>>GFRAC, using a CW+GW bit product, truncating, then saturating to 2^CW-1.
  - invert: (2^CW-1)-ch.
  - bypass: ch.
- pix_count: on an m handshake with m_sof=1, load 1. On other m handshakes, increment, saturating at 2^CNT_W-1. Otherwise hold, so the final frame length stays visible after eof.
- frame_done: registered and high for exactly 1 cycle, the cycle after an m handshake with m_eof=1.
- sof=eof=1 on the same beat (single-pixel frame): config loads, pix_count=1, frame_done pulses.
- sof arriving without a preceding eof: accepted; the count restarts and no error is raised.
- Reset asserted mid-frame: all outputs return to reset values immediately. The next frame must start with sof to load config.

Decomposition:
- Shared package pixel_pkg holds:
  - mode encodings MODE_BYPASS..MODE_INVERT
  - default CW/NCH/GW/GFRAC
  - a channel-max constant function
- One natural sub-module, pixel_adjust_chan: a combinational per-channel operator (mode, offset, gain, ch in → ch out, saturating). It is instantiated NCH times via generate inside stage 1→2.

Test Plan:
- Bypass after reset: frame of 4 pixels 0x102030, 0xFFFFFF, 0x000000, 0x7F8081 with m_ready=1 → identical m_data 2 cycles after each input, pix_count 1..4, frame_done 1 cycle after 4th output.
- Add saturation: sof beat cfg_mode=1, offset=0x40, pixel 0xF0_20_C0 → 0xFF_60_FF; mode 2 same pixel → 0xB0_00_80.
- Gain and invert: mode 3, gain 0x18 (1.5), pixel 0x10_AA_80 → 0x18_FF_C0; mode 4, pixel 0x00_7F_FF → 0xFF_80_00.
- Backpressure: stream 8 pixels, m_ready toggling 1,0,0,1,... → no pixel lost or duplicated, m_data stable during stalls, order preserved, s_ready low exactly when m_valid=1 and m_ready=0.
- Config isolation: change cfg_* mid-frame (non-sof beats) → output unaffected until next sof; single-pixel frame (sof=eof) → new config applied, pix_count=1, frame_done pulses once.
- Reset mid-frame: assert rst with 2 beats in flight → m_valid=0, pix_count=0 immediately; the next frame without cfg reload on sof runs with the cfg values presented at its sof.
